load_store_unit: RTL and testbench

Data-memory access engine for the RV32I core. It consumes the memory controls produced by the instruction decoder (`data_r`, `data_w`, `data_size`, `unsigned_value`), the effective address from the ALU and the store value from rs2. It runs one request/acknowledge transaction on the word-wide data bus and returns an aligned, sign- or zero-extended load result for the `rd_data_sel = 01` path.

---
 rtl/load_store_unit_pkg.sv | 34 +++
 rtl/load_store_unit_if.sv | 20 ++
 rtl/load_store_unit_lane_align.sv | 58 +++++
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV32I load/store unit: access sizes, FSM state
// encodings and the request legality check.
package load_store_unit_pkg;

  localparam logic [1:0] LS_SIZE_BYTE    = 2'b00;
  localparam logic [1:0] LS_SIZE_HALF    = 2'b01;
  localparam logic [1:0] LS_SIZE_WORD    = 2'b10;
  localparam logic [1:0] LS_SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    LS_ST_IDLE = 2'b00,
    LS_ST_REQ  = 2'b01,
    LS_ST_DONE = 2'b10,
    LS_ST_ERR  = 2'b11
  } ls_state_e;

  // An access is rejected before touching the bus when it is neither a pure
  // load nor a pure store, has an illegal size, or is misaligned for its size.
  function automatic logic ls_access_illegal(input logic       rd,
                                             input logic       wr,
                                             input logic [1:0] size,
                                             input logic [1:0] addr_lo);
    logic bad;
    bad = (rd == wr);
    case (size)
      LS_SIZE_BYTE: bad = bad;
      LS_SIZE_HALF: bad = bad | addr_lo[0];
      LS_SIZE_WORD: bad = bad | (addr_lo != 2'b00);
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide request/acknowledge data bus between the load/store unit and memory.
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte-lane steering: store strobes/replicated data and the
// aligned, sign- or zero-extended load result.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic        is_store,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic        [7:0]  ld_byte;
  logic        [15:0] ld_half;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_sx;
  logic signed [31:0] half_sx;

  always_comb begin
    case (addr_lo)
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    byte_s  = ld_byte;
    half_s  = ld_half;
    byte_sx = 32'(byte_s);
    half_sx = 32'(half_s);

    wstrb   = 4'b0000;
    wdata   = st_data;
    ld_data = rd_word;
    case (size)
      LS_SIZE_BYTE: begin
        wstrb   = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = is_unsigned ? {24'b0, ld_byte} : byte_sx;
      end
      LS_SIZE_HALF: begin
        wstrb   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{st_data[15:0]}};
        ld_data = is_unsigned ? {16'b0, ld_half} : half_sx;
      end
      LS_SIZE_WORD: wstrb = 4'b1111;
      default:      wstrb = 4'b0000;
    endcase
    // Loads never enable byte lanes on the bus.
    if (!is_store) wstrb = 4'b0000;
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory access engine: latches one decoded load/store, runs a
// single req/ack bus transaction and returns the extended load result.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               data_r,
  input  logic               data_w,
  input  logic [1:0]         data_size,
  input  logic               unsigned_value,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rd_data,
  output logic               done,
  output logic               err,
  output logic               busy,
  load_store_unit_if.master  bus
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  ls_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_load_q, is_load_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [3:0]        bus_wstrb_q, bus_wstrb_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;

  logic              in_idle;
  logic [1:0]        al_addr_lo;
  logic [1:0]        al_size;
  logic              al_uns;
  logic [3:0]        al_wstrb;
  logic [31:0]       al_wdata;
  logic [31:0]       al_ld;

  // One aligner serves both phases: raw inputs while idle (store lanes for the
  // upcoming request), latched fields afterwards (load extraction on ack).
  assign in_idle    = (state_q == LS_ST_IDLE);
  assign al_addr_lo = in_idle ? addr[1:0]      : addr_lo_q;
  assign al_size    = in_idle ? data_size      : size_q;
  assign al_uns     = in_idle ? unsigned_value : uns_q;

  lsu_lane_align u_align (
    .addr_lo     (al_addr_lo),
    .size        (al_size),
    .is_unsigned (al_uns),
    .is_store    (data_w),
    .st_data     (wdata),
    .rd_word     (bus.bus_rdata),
    .wstrb       (al_wstrb),
    .wdata       (al_wdata),
    .ld_data     (al_ld)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_load_d   = is_load_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_lo_d   = addr_lo_q;
    rd_data_d   = rd_data_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;

    case (state_q)
      LS_ST_IDLE: begin
        if (start) begin
          is_load_d = data_r;
          size_d    = data_size;
          uns_d     = unsigned_value;
          addr_lo_d = addr[1:0];
          if (ls_access_illegal(data_r, data_w, data_size, addr[1:0])) begin
            state_d = LS_ST_ERR;
          end else begin
            state_d     = LS_ST_REQ;
            cnt_d       = '0;
            bus_we_d    = data_w;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_wstrb_d = al_wstrb;
            bus_wdata_d = al_wdata;
          end
        end
      end
      LS_ST_REQ: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (bus.bus_ack) begin
          if (is_load_q) rd_data_d = al_ld;
          state_d = LS_ST_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = LS_ST_ERR;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LS_ST_DONE: state_d = LS_ST_IDLE;
      LS_ST_ERR:  state_d = LS_ST_IDLE;
      default:    state_d = LS_ST_IDLE;
    endcase

    // Outputs are registered copies of the next state's decode.
    done_d    = (state_d == LS_ST_DONE);
    err_d     = (state_d == LS_ST_ERR);
    busy_d    = (state_d != LS_ST_IDLE);
    bus_req_d = (state_d == LS_ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LS_ST_IDLE;
      cnt_q       <= '0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Request fields are only consumed after a start, so they need no reset.
  always_ff @(posedge clk) begin
    is_load_q <= is_load_d;
    size_q    <= size_d;
    uns_q     <= uns_d;
    addr_lo_q <= addr_lo_d;
  end

  assign rd_data       = rd_data_q;
  assign done          = done_q;
  assign err           = err_q;
  assign busy          = busy_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wstrb = bus_wstrb_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: one instance with the timeout disabled
// and one with TIMEOUT=4, sharing the request inputs.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  typedef struct {
    logic r, w; logic [1:0] sz; logic u;
    logic [31:0] a, wd, rdw; int waits;
  } stim_t;

  typedef struct {
    logic done, err; int lat; logic [31:0] rd; logic saw_req;
    logic [31:0] baddr; logic [3:0] wstrb; logic [31:0] bwdata; logic we; logic stable;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, data_r, data_w, unsigned_value;
  logic [1:0]  data_size;
  logic [31:0] addr, wdata;
  logic [31:0] rd0, rd4;
  logic        done0, err0, busy0, done4, err4, busy4;

  int checks = 0;
  int failures = 0;
  obs_t exp_q[$];

  load_store_unit_if bus0();
  load_store_unit_if bus4();

  load_store_unit #(.TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .data_r(data_r), .data_w(data_w),
    .data_size(data_size), .unsigned_value(unsigned_value), .addr(addr), .wdata(wdata),
    .rd_data(rd0), .done(done0), .err(err0), .busy(busy0), .bus(bus0)
  );

  load_store_unit #(.TIMEOUT(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .data_r(data_r), .data_w(data_w),
    .data_size(data_size), .unsigned_value(unsigned_value), .addr(addr), .wdata(wdata),
    .rd_data(rd4), .done(done4), .err(err4), .busy(busy4), .bus(bus4)
  );

  function automatic obs_t mk_ok(int lat, logic [31:0] rd, logic [31:0] baddr,
                                 logic [3:0] ws, logic [31:0] bw, logic we);
    obs_t e;
    e.done = 1'b1; e.err = 1'b0; e.lat = lat; e.rd = rd; e.saw_req = 1'b1;
    e.baddr = baddr; e.wstrb = ws; e.bwdata = bw; e.we = we; e.stable = 1'b1;
    return e;
  endfunction

  function automatic obs_t mk_err(int lat, logic [31:0] rd, logic saw_req);
    obs_t e;
    e = mk_ok(lat, rd, 32'h0, 4'h0, 32'h0, 1'b0);
    e.done = 1'b0; e.err = 1'b1; e.saw_req = saw_req;
    return e;
  endfunction

  // Drives one access and records what the DUT did; waits < 0 means no ack.
  // A second start is pulsed in cycle restart_cyc (0 = never).
  task automatic run_access(input stim_t s, input bit use4, input int restart_cyc,
                            output obs_t o);
    logic d, e, rq, we;
    logic [31:0] ba, bw;
    logic [3:0] st;
    o.done = 0; o.err = 0; o.lat = -1; o.rd = 0; o.saw_req = 0;
    o.baddr = 0; o.wstrb = 0; o.bwdata = 0; o.we = 0; o.stable = 1;
    data_r = s.r; data_w = s.w; data_size = s.sz; unsigned_value = s.u;
    addr = s.a; wdata = s.wd; bus0.bus_rdata = s.rdw; bus4.bus_rdata = s.rdw;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      bus0.bus_ack = 1'b0; bus4.bus_ack = 1'b0;
      start = (cyc == restart_cyc);
      if (start) begin
        addr = s.a + 32'h100; data_r = ~s.r; data_w = ~s.w; wdata = ~s.wd;
      end
      d  = use4 ? done4 : done0;
      e  = use4 ? err4  : err0;
      rq = use4 ? bus4.bus_req   : bus0.bus_req;
      we = use4 ? bus4.bus_we    : bus0.bus_we;
      ba = use4 ? bus4.bus_addr  : bus0.bus_addr;
      st = use4 ? bus4.bus_wstrb : bus0.bus_wstrb;
      bw = use4 ? bus4.bus_wdata : bus0.bus_wdata;
      if (rq) begin
        if (!o.saw_req) begin
          o.baddr = ba; o.wstrb = st; o.bwdata = bw; o.we = we;
        end else if (ba !== o.baddr || st !== o.wstrb || bw !== o.bwdata || we !== o.we) begin
          o.stable = 1'b0;
        end
        o.saw_req = 1'b1;
      end
      if (d || e) begin
        o.done = d; o.err = e; o.lat = cyc; o.rd = use4 ? rd4 : rd0;
        break;
      end
      if (s.waits >= 0 && cyc == s.waits + 1) begin
        bus0.bus_ack = 1'b1; bus4.bus_ack = 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; bus0.bus_ack = 1'b0; bus4.bus_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; data_r = 0; data_w = 0; data_size = 0; unsigned_value = 0;
    addr = 0; wdata = 0; bus0.bus_ack = 0; bus4.bus_ack = 0; bus0.bus_rdata = 0; bus4.bus_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset.done got %b want 0", done0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL reset.err got %b want 0", err0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset.busy got %b want 0", busy0); end
    checks++; if (bus0.bus_req !== 1'b0) begin failures++; $display("FAIL reset.bus_req got %b want 0", bus0.bus_req); end
    checks++; if (bus0.bus_we !== 1'b0) begin failures++; $display("FAIL reset.bus_we got %b want 0", bus0.bus_we); end
    checks++; if (bus0.bus_addr !== 32'h0) begin failures++; $display("FAIL reset.bus_addr got %h want 0", bus0.bus_addr); end
    checks++; if (bus0.bus_wstrb !== 4'h0) begin failures++; $display("FAIL reset.bus_wstrb got %b want 0", bus0.bus_wstrb); end
    checks++; if (bus0.bus_wdata !== 32'h0) begin failures++; $display("FAIL reset.bus_wdata got %h want 0", bus0.bus_wdata); end
    checks++; if (rd0 !== 32'h0) begin failures++; $display("FAIL reset.rd_data got %h want 0", rd0); end
    checks++;
    if ({done4, err4, busy4, bus4.bus_req, bus4.bus_we, bus4.bus_addr, bus4.bus_wstrb, bus4.bus_wdata, rd4} !== '0) begin
      failures++; $display("FAIL reset.dut4 outputs not all zero");
    end
  endtask

  task automatic test_loads();
    stim_t s[6];
    obs_t o, e;
    s[0] = '{1'b1, 1'b0, LS_SIZE_BYTE, 1'b0, 32'h103, 32'h0, 32'h80FF_1234, 0};
    s[1] = '{1'b1, 1'b0, LS_SIZE_BYTE, 1'b1, 32'h103, 32'h0, 32'h80FF_1234, 0};
    s[2] = '{1'b1, 1'b0, LS_SIZE_HALF, 1'b0, 32'h202, 32'h0, 32'h9ABC_0000, 0};
    s[3] = '{1'b1, 1'b0, LS_SIZE_HALF, 1'b1, 32'h200, 32'h0, 32'h1234_8001, 1};
    s[4] = '{1'b1, 1'b0, LS_SIZE_BYTE, 1'b0, 32'h101, 32'h0, 32'h0000_7F00, 0};
    s[5] = '{1'b1, 1'b0, LS_SIZE_WORD, 1'b0, 32'h204, 32'h0, 32'h1357_9BDF, 3};
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: exp_q.push_back(mk_ok(2, 32'hFFFF_FF80, 32'h100, 4'h0, 32'h0, 1'b0));
        1: exp_q.push_back(mk_ok(2, 32'h0000_0080, 32'h100, 4'h0, 32'h0, 1'b0));
        2: exp_q.push_back(mk_ok(2, 32'hFFFF_9ABC, 32'h200, 4'h0, 32'h0, 1'b0));
        3: exp_q.push_back(mk_ok(3, 32'h0000_8001, 32'h200, 4'h0, 32'h0, 1'b0));
        4: exp_q.push_back(mk_ok(2, 32'h0000_007F, 32'h100, 4'h0, 32'h0, 1'b0));
        default: exp_q.push_back(mk_ok(5, 32'h1357_9BDF, 32'h204, 4'h0, 32'h0, 1'b0));
      endcase
      run_access(s[i], 1'b0, 0, o);
      e = exp_q.pop_front();
      checks++; if (o.done !== e.done || o.err !== e.err) begin failures++; $display("FAIL load%0d done/err got %b/%b want %b/%b", i, o.done, o.err, e.done, e.err); end
      checks++; if (o.lat !== e.lat) begin failures++; $display("FAIL load%0d latency got %0d want %0d", i, o.lat, e.lat); end
      checks++; if (o.rd !== e.rd) begin failures++; $display("FAIL load%0d rd_data got %h want %h", i, o.rd, e.rd); end
      checks++; if (o.baddr !== e.baddr || o.we !== e.we || o.wstrb !== e.wstrb) begin
        failures++; $display("FAIL load%0d bus addr/we/wstrb got %h/%b/%b want %h/%b/%b", i, o.baddr, o.we, o.wstrb, e.baddr, e.we, e.wstrb);
      end
    end
  endtask

  task automatic test_stores();
    stim_t s[5];
    obs_t o, e;
    s[0] = '{1'b0, 1'b1, LS_SIZE_BYTE, 1'b0, 32'h011, 32'h0000_00A5, 32'hFFFF_FFFF, 0};
    s[1] = '{1'b0, 1'b1, LS_SIZE_HALF, 1'b0, 32'h012, 32'h0000_BEEF, 32'hFFFF_FFFF, 1};
    s[2] = '{1'b0, 1'b1, LS_SIZE_HALF, 1'b0, 32'h010, 32'hCAFE_1234, 32'hFFFF_FFFF, 0};
    s[3] = '{1'b0, 1'b1, LS_SIZE_WORD, 1'b0, 32'h020, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 2};
    s[4] = '{1'b0, 1'b1, LS_SIZE_BYTE, 1'b0, 32'h013, 32'h1234_565A, 32'hFFFF_FFFF, 0};
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: exp_q.push_back(mk_ok(2, 32'h1357_9BDF, 32'h010, 4'b0010, 32'hA5A5_A5A5, 1'b1));
        1: exp_q.push_back(mk_ok(3, 32'h1357_9BDF, 32'h010, 4'b1100, 32'hBEEF_BEEF, 1'b1));
        2: exp_q.push_back(mk_ok(2, 32'h1357_9BDF, 32'h010, 4'b0011, 32'h1234_1234, 1'b1));
        3: exp_q.push_back(mk_ok(4, 32'h1357_9BDF, 32'h020, 4'b1111, 32'hDEAD_BEEF, 1'b1));
        default: exp_q.push_back(mk_ok(2, 32'h1357_9BDF, 32'h010, 4'b1000, 32'h5A5A_5A5A, 1'b1));
      endcase
      run_access(s[i], 1'b0, 0, o);
      e = exp_q.pop_front();
      checks++; if (o.done !== e.done || o.lat !== e.lat) begin failures++; $display("FAIL store%0d done/latency got %b/%0d want %b/%0d", i, o.done, o.lat, e.done, e.lat); end
      checks++; if (o.baddr !== e.baddr) begin failures++; $display("FAIL store%0d bus_addr got %h want %h", i, o.baddr, e.baddr); end
      checks++; if (o.wstrb !== e.wstrb || o.we !== e.we) begin failures++; $display("FAIL store%0d wstrb/we got %b/%b want %b/%b", i, o.wstrb, o.we, e.wstrb, e.we); end
      checks++; if (o.bwdata !== e.bwdata) begin failures++; $display("FAIL store%0d bus_wdata got %h want %h", i, o.bwdata, e.bwdata); end
      checks++; if (o.stable !== e.stable) begin failures++; $display("FAIL store%0d bus stability got %b want %b", i, o.stable, e.stable); end
      checks++; if (o.rd !== e.rd) begin failures++; $display("FAIL store%0d rd_data got %h want %h", i, o.rd, e.rd); end
    end
  endtask

  task automatic test_errors();
    stim_t s[6];
    obs_t o, e;
    s[0] = '{1'b1, 1'b0, LS_SIZE_WORD,    1'b0, 32'h102, 32'h0, 32'hAAAA_AAAA, 0};
    s[1] = '{1'b0, 1'b1, LS_SIZE_HALF,    1'b0, 32'h001, 32'h1, 32'hAAAA_AAAA, 0};
    s[2] = '{1'b1, 1'b0, LS_SIZE_ILLEGAL, 1'b0, 32'h000, 32'h0, 32'hAAAA_AAAA, 0};
    s[3] = '{1'b1, 1'b1, LS_SIZE_WORD,    1'b0, 32'h000, 32'h0, 32'hAAAA_AAAA, 0};
    s[4] = '{1'b0, 1'b0, LS_SIZE_WORD,    1'b0, 32'h000, 32'h0, 32'hAAAA_AAAA, 0};
    s[5] = '{1'b1, 1'b0, LS_SIZE_HALF,    1'b0, 32'h203, 32'h0, 32'hAAAA_AAAA, 0};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(mk_err(1, 32'h1357_9BDF, 1'b0));
      run_access(s[i], 1'b0, 0, o);
      e = exp_q.pop_front();
      checks++; if (o.err !== e.err || o.done !== e.done) begin failures++; $display("FAIL err%0d err/done got %b/%b want %b/%b", i, o.err, o.done, e.err, e.done); end
      checks++; if (o.lat !== e.lat) begin failures++; $display("FAIL err%0d latency got %0d want %0d", i, o.lat, e.lat); end
      checks++; if (o.saw_req !== e.saw_req) begin failures++; $display("FAIL err%0d bus_req seen got %b want %b", i, o.saw_req, e.saw_req); end
      checks++; if (o.rd !== e.rd) begin failures++; $display("FAIL err%0d rd_data got %h want %h", i, o.rd, e.rd); end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    obs_t o, e;
    int stray;
    s = '{1'b1, 1'b0, LS_SIZE_WORD, 1'b0, 32'h300, 32'h0, 32'h1122_3344, 2};
    exp_q.push_back(mk_ok(4, 32'h1122_3344, 32'h300, 4'h0, 32'h0, 1'b0));
    run_access(s, 1'b0, 2, o);
    e = exp_q.pop_front();
    checks++; if (o.done !== e.done || o.lat !== e.lat) begin failures++; $display("FAIL busy_start done/latency got %b/%0d want %b/%0d", o.done, o.lat, e.done, e.lat); end
    checks++; if (o.rd !== e.rd || o.stable !== e.stable) begin failures++; $display("FAIL busy_start rd/stable got %h/%b want %h/%b", o.rd, o.stable, e.rd, e.stable); end
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus0.bus_req || busy0 || done0 || err0) stray++;
      @(posedge clk); #1;
    end
    checks++; if (stray !== 0) begin failures++; $display("FAIL busy_start queued activity got %0d cycles want 0", stray); end
    s = '{1'b1, 1'b0, LS_SIZE_BYTE, 1'b0, 32'h302, 32'h0, 32'h00C3_0000, 0};
    exp_q.push_back(mk_ok(2, 32'hFFFF_FFC3, 32'h300, 4'h0, 32'h0, 1'b0));
    run_access(s, 1'b0, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.done !== e.done || o.lat !== e.lat || o.rd !== e.rd) begin
      failures++; $display("FAIL back_to_back done/lat/rd got %b/%0d/%h want %b/%0d/%h", o.done, o.lat, o.rd, e.done, e.lat, e.rd);
    end
  endtask

  task automatic test_timeout();
    stim_t s;
    obs_t o, e;
    s = '{1'b1, 1'b0, LS_SIZE_WORD, 1'b0, 32'h400, 32'h0, 32'h0BAD_F00D, -1};
    exp_q.push_back(mk_err(5, 32'h0, 1'b1));
    run_access(s, 1'b1, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.err !== e.err || o.done !== e.done || o.lat !== e.lat) begin
      failures++; $display("FAIL timeout err/done/lat got %b/%b/%0d want %b/%b/%0d", o.err, o.done, o.lat, e.err, e.done, e.lat);
    end
    checks++; if (busy0 !== 1'b1 || bus0.bus_req !== 1'b1) begin failures++; $display("FAIL no_timeout still waiting got busy=%b req=%b want 1/1", busy0, bus0.bus_req); end
    bus0.bus_ack = 1'b1; bus4.bus_ack = 1'b1;
    @(posedge clk); #1;
    bus0.bus_ack = 1'b0; bus4.bus_ack = 1'b0;
    checks++; if (done0 !== 1'b1 || rd0 !== 32'h0BAD_F00D) begin failures++; $display("FAIL no_timeout late ack got done=%b rd=%h want 1/0badf00d", done0, rd0); end
    checks++; if (done4 !== 1'b0 || err4 !== 1'b0) begin failures++; $display("FAIL idle_ack got done=%b err=%b want 0/0", done4, err4); end
    @(posedge clk); #1;
    s = '{1'b1, 1'b0, LS_SIZE_WORD, 1'b0, 32'h404, 32'h0, 32'h7777_1111, 3};
    exp_q.push_back(mk_ok(5, 32'h7777_1111, 32'h404, 4'h0, 32'h0, 1'b0));
    run_access(s, 1'b1, 0, o);
    e = exp_q.pop_front();
    checks++; if (o.done !== e.done || o.err !== e.err || o.lat !== e.lat) begin
      failures++; $display("FAIL ack_at_timeout done/err/lat got %b/%b/%0d want %b/%b/%0d", o.done, o.err, o.lat, e.done, e.err, e.lat);
    end
    checks++; if (o.rd !== e.rd) begin failures++; $display("FAIL ack_at_timeout rd_data got %h want %h", o.rd, e.rd); end
  endtask

  task automatic test_reset_mid();
    int bad;
    data_r = 1; data_w = 0; data_size = LS_SIZE_WORD; unsigned_value = 0; addr = 32'h500;
    bus0.bus_rdata = 32'h5555_AAAA; bus4.bus_rdata = 32'h5555_AAAA;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (bus0.bus_req !== 1'b1) begin failures++; $display("FAIL reset_mid first REQ got req=%b want 1", bus0.bus_req); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus0.bus_ack = 1'b1; bus4.bus_ack = 1'b1;
    checks++; if (bus0.bus_req !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL reset_mid req/busy got %b/%b want 0/0", bus0.bus_req, busy0); end
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      bus0.bus_ack = 1'b0; bus4.bus_ack = 1'b0;
      if (done0 || err0 || bus0.bus_req || done4 || err4) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL reset_mid stray ack activity got %0d cycles want 0", bad); end
    checks++; if (rd0 !== 32'h0) begin failures++; $display("FAIL reset_mid rd_data got %h want 0", rd0); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
